// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ID/EX register layout and immediate helper.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Everything the execute stage receives from decode.
    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic        jump;
        alu_ctrl_e   alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } idex_t;

    // Sign-extended immediate for the four formats; bit 31 is always the sign.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_cycle_regfile.sv
// 32x32 architectural register file: two combinational read ports, one
// write port, x0 hardwired to zero, optional write-before-read forwarding.
module register_file
    import riscv_pkg::*;
#(
    parameter int REG_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic [31:0] WD3,
    input  logic        WE3,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);

    logic [31:0][31:0] regs_q;
    logic              wr_en;

    assign wr_en = WE3 && (A3 != 5'd0);

    // Register array: async clear, writes to x0 dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else if (wr_en) begin
            regs_q[A3] <= WD3;
        end
    end

    // Read ports; a same-cycle write to the read index wins when bypass is on.
    always_comb begin
        RD1 = (A1 == 5'd0) ? 32'd0 : regs_q[A1];
        RD2 = (A2 == 5'd0) ? 32'd0 : regs_q[A2];
        if (REG_BYPASS != 0) begin
            if (wr_en && (A3 == A1)) RD1 = WD3;
            if (wr_en && (A3 == A2)) RD2 = WD3;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, register read
// and the ID/EX pipeline register feeding execute.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int REG_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        MemWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E,
    output logic [4:0]  RD_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rd1, rd2;
    logic        reg_write, alu_src, mem_write, branch, jump, imm_en;
    result_src_e result_src;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_ctrl;
    idex_t       idex_d, idex_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];

    register_file #(.REG_BYPASS(REG_BYPASS)) u_rf (
        .clk (clk),
        .rst (rst),
        .A1  (InstrD[19:15]),
        .A2  (InstrD[24:20]),
        .A3  (RDW),
        .WD3 (ResultW),
        .WE3 (RegWriteW),
        .RD1 (rd1),
        .RD2 (rd2)
    );

    // Main decoder: unknown opcodes fall through to an all-zero bubble.
    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = RES_ALU;
        branch     = 1'b0;
        jump       = 1'b0;
        imm_src    = IMM_I;
        imm_en     = 1'b0;
        case (opcode)
            OP_LW:  begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM;
                          imm_src = IMM_I; imm_en = 1'b1; end
            OP_SW:  begin alu_src = 1'b1; mem_write = 1'b1;
                          imm_src = IMM_S; imm_en = 1'b1; end
            OP_R:   begin reg_write = 1'b1; end
            OP_I:   begin reg_write = 1'b1; alu_src = 1'b1;
                          imm_src = IMM_I; imm_en = 1'b1; end
            OP_BEQ: begin branch = 1'b1; imm_src = IMM_B; imm_en = 1'b1; end
            OP_JAL: begin reg_write = 1'b1; result_src = RES_PC4; jump = 1'b1;
                          imm_src = IMM_J; imm_en = 1'b1; end
            default: ;
        endcase
    end

    // ALU decoder: funct7[5] selects sub only for R-type; I-ALU ignores it.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (opcode)
            OP_BEQ: alu_ctrl = ALU_SUB;
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  alu_ctrl = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // Assemble the next ID/EX contents; formats without an immediate carry 0.
    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = reg_write;
        idex_d.alu_src    = alu_src;
        idex_d.mem_write  = mem_write;
        idex_d.result_src = result_src;
        idex_d.branch     = branch;
        idex_d.jump       = jump;
        idex_d.alu_ctrl   = alu_ctrl;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm        = imm_en ? imm_extend(InstrD, imm_src) : 32'd0;
        idex_d.rs1        = InstrD[19:15];
        idex_d.rs2        = InstrD[24:20];
        idex_d.rd         = InstrD[11:7];
        idex_d.pc         = PCD;
        idex_d.pc_plus4   = PCPlus4D;
    end

    // ID/EX register: reset beats flush; flush zeroes every field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign ALUSrcE     = idex_q.alu_src;
    assign MemWriteE   = idex_q.mem_write;
    assign ResultSrcE  = idex_q.result_src;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign RD_E        = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: expected ID/EX contents are queued as
// each instruction is driven and compared once the edge has loaded them.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;

    int total = 0;
    int bad   = 0;

    // ctl = {RegWrite, ALUSrc, MemWrite, ResultSrc[1:0], Branch, Jump, ALUControl[2:0]}
    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
        logic        chk_imm;
    } exp_t;

    localparam logic [9:0] C_ADDI = 10'b1100000000;
    localparam logic [9:0] C_RADD = 10'b1000000000;
    localparam logic [9:0] C_RSUB = 10'b1000000001;
    localparam logic [9:0] C_ROR  = 10'b1000000011;
    localparam logic [9:0] C_SLTI = 10'b1100000101;
    localparam logic [9:0] C_BEQ  = 10'b0000010001;
    localparam logic [9:0] C_SW   = 10'b0110000000;
    localparam logic [9:0] C_JAL  = 10'b1001001000;
    localparam logic [9:0] C_LW   = 10'b1100100000;

    exp_t exp_q[$];

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [9:0] ctl, input logic [31:0] rd1, rd2, imm,
                                input logic [4:0] rs1, rs2, rd, input logic [31:0] pc);
        exp_t e;
        e.ctl = ctl; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.pc4 = pc + 32'd4;
        e.chk_imm = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s observed=empty-scoreboard expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".ctl"}, 32'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE}),
            32'(e.ctl));
        chk({tag, ".rd1"}, RD1_E, e.rd1);
        chk({tag, ".rd2"}, RD2_E, e.rd2);
        if (e.chk_imm) chk({tag, ".imm"}, Imm_Ext_E, e.imm);
        chk({tag, ".rs1"}, 32'(RS1_E), 32'(e.rs1));
        chk({tag, ".rs2"}, 32'(RS2_E), 32'(e.rs2));
        chk({tag, ".rd"},  32'(RD_E),  32'(e.rd));
        chk({tag, ".pc"},  PCE, e.pc);
        chk({tag, ".pc4"}, PCPlus4E, e.pc4);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        exp_t z;
        z = '0;
        z.chk_imm = 1'b1;
        rst = 1'b0; FlushE = 1'b0;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
        drive(32'hFFD00293, 32'h0);

        // Reset held with a live instruction: everything stays zero.
        exp_q.push_back(z);
        repeat (3) @(posedge clk);
        #1;
        check_now("reset");

        // Release; all-zero instruction decodes as a bubble.
        rst = 1'b1;
        drive(32'h0, 32'h0);
        begin exp_t e; e = mk(10'b0, 0, 0, 0, 0, 0, 0, 32'h0); e.chk_imm = 1'b0; exp_q.push_back(e); end
        step("bubble");

        drive(32'hFFD00293, 32'h10);                       // addi x5,x0,-3
        exp_q.push_back(mk(C_ADDI, 0, 0, 32'hFFFFFFFD, 0, 29, 5, 32'h10));
        step("addi");

        RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h12345678;
        drive(32'h006303B3, 32'h14);                       // add x7,x6,x6 with bypass
        exp_q.push_back(mk(C_RADD, 32'h12345678, 32'h12345678, 0, 6, 6, 7, 32'h14));
        step("add_bypass");
        RegWriteW = 1'b0;
        exp_q.push_back(mk(C_RADD, 32'h12345678, 32'h12345678, 0, 6, 6, 7, 32'h14));
        step("add_stored");

        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hDEADBEEF;
        drive(32'h00000033, 32'h1C);                       // add x0,x0,x0
        exp_q.push_back(mk(C_RADD, 0, 0, 0, 0, 0, 0, 32'h1C));
        step("x0_write");
        RegWriteW = 1'b0;
        exp_q.push_back(mk(C_RADD, 0, 0, 0, 0, 0, 0, 32'h1C));
        step("x0_read");

        drive(32'hFE208CE3, 32'h40);                       // beq x1,x2,-8
        exp_q.push_back(mk(C_BEQ, 0, 0, 32'hFFFFFFF8, 1, 2, 25, 32'h40));
        step("beq");

        drive(32'h40630433, 32'h44);                       // sub x8,x6,x6
        exp_q.push_back(mk(C_RSUB, 32'h12345678, 32'h12345678, 0, 6, 6, 8, 32'h44));
        step("sub");

        drive(32'h006363B3, 32'h48);                       // or x7,x6,x6
        exp_q.push_back(mk(C_ROR, 32'h12345678, 32'h12345678, 0, 6, 6, 7, 32'h48));
        step("or");

        drive(32'h40000293, 32'h4C);                       // addi x5,x0,0x400 (bit30 set, still add)
        exp_q.push_back(mk(C_ADDI, 0, 0, 32'h00000400, 0, 0, 5, 32'h4C));
        step("addi_b30");

        drive(32'hFFF02413, 32'h50);                       // slti x8,x0,-1
        exp_q.push_back(mk(C_SLTI, 0, 0, 32'hFFFFFFFF, 0, 31, 8, 32'h50));
        step("slti");

        drive(32'hFE732E23, 32'h54);                       // sw x7,-4(x6)
        exp_q.push_back(mk(C_SW, 32'h12345678, 0, 32'hFFFFFFFC, 6, 7, 28, 32'h54));
        step("sw");

        drive(32'h010000EF, 32'h58);                       // jal x1,+16
        exp_q.push_back(mk(C_JAL, 0, 0, 32'h00000010, 0, 16, 1, 32'h58));
        step("jal");

        // Flush squashes the addi but the writeback to x9 still lands.
        drive(32'hFFD00293, 32'h5C);
        FlushE = 1'b1; RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'hA5A5A5A5;
        exp_q.push_back(z);
        step("flush");
        FlushE = 1'b0; RegWriteW = 1'b0;

        drive(32'h00048513, 32'h60);                       // addi x10,x9,0
        exp_q.push_back(mk(C_ADDI, 32'hA5A5A5A5, 0, 0, 9, 0, 10, 32'h60));
        step("flush_wb");

        drive(32'h00432583, 32'h64);                       // lw x11,4(x6)
        exp_q.push_back(mk(C_LW, 32'h12345678, 0, 32'h4, 6, 4, 11, 32'h64));
        step("lw");

        // Mid-cycle reset clears outputs without waiting for an edge.
        #3;
        rst = 1'b0;
        exp_q.push_back(z);
        #1;
        check_now("async_rst");

        @(negedge clk);
        rst = 1'b1;
        drive(32'h006303B3, 32'h80);                       // x6 must now read 0
        exp_q.push_back(mk(C_RADD, 0, 0, 0, 6, 6, 7, 32'h80));
        step("post_rst");

        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Second stage of the 5-stage RV32I pipeline, directly downstream of fetch_cycle.
- Consumes InstrD/PCD/PCPlus4D.
- Decodes control signals and generates the sign-extended immediate.
- Reads the architectural register file, which it owns and which is written back from the W stage.
- Registers everything into the ID/EX pipeline register feeding the execute stage.

Parameters:
REG_BYPASS, 1, 1 = same-cycle W-stage write is forwarded to D-stage reads (write-before-read); 0 = read returns the old value.

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
InstrD  in  32  instruction from IF/ID register
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RDW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  synchronous bubble insert into ID/EX
RegWriteE  out  1  register write enable
ALUSrcE  out  1  0 = RD2, 1 = immediate
MemWriteE  out  1  store
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
BranchE  out  1  beq
JumpE  out  1  jal
ALUControlE  out  3  ALU operation
RD1_E  out  32  rs1 data
RD2_E  out  32  rs2 data
Imm_Ext_E  out  32  sign-extended immediate
RS1_E  out  5  rs1 index (for hazard unit)
RS2_E  out  5  rs2 index
RD_E  out  5  rd index
PCE  out  32  PC
PCPlus4E  out  32  PC+4

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
  - rst=0 immediately clears all ID/EX outputs to 0 and all 32 registers to 0.
  - rst dominates FlushE and writeback.
- Latency: 1 cycle. D-stage inputs sampled at posedge clk appear on *E outputs after that edge. No stall input; the register loads every cycle.
- Decode (opcode InstrD[6:0]); each row gives RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ImmSrc:
  - lw 0000011: 1, 1, 0, 01, 0, 0, I
  - sw 0100011: 0, 1, 1, 00, 0, 0, S
  - R-type 0110011: 1, 0, 0, 00, 0, 0, -
  - I-ALU 0010011: 1, 1, 0, 00, 0, 0, I
  - beq 1100011: 0, 0, 0, 00, 1, 0, B
  - jal 1101111: 1, 0, 0, 10, 0, 1, J
  - Any other opcode (including 0x00000000): all control 0, i.e. a bubble.
- ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - lw/sw/jal: add. beq: sub.
  - R/I-ALU by funct3: 000 gives add, or sub only when R-type and funct7[5]=1; 010 slt; 110 or; 111 and.
  - Other funct3: add.
- Immediate formats, all sign-extended from InstrD[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - Opcodes without an immediate: Imm_Ext_E is don't-care, and the bench checks 0 for R-type.
- Register file: 32x32.
  - Write at posedge clk when RegWriteW=1 and RDW!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - Reads are combinational on InstrD[19:15] and [24:20].
  - REG_BYPASS=1: if RegWriteW and RDW!=0 and RDW==rs, the read returns ResultW in the same cycle.
- FlushE=1 at a posedge: all ID/EX fields (control and data) load 0. The register-file write in that cycle still occurs.
- Reset mid-operation: outputs go to 0 asynchronously. The first edge after release loads a normal decode of InstrD.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants
  - ALUControl codes
  - ImmSrc codes (00 I, 01 S, 10 B, 11 J)
  - ResultSrc codes
- Sub-module register_file (clk, rst, A1, A2, A3, WD3, WE3, RD1, RD2, REG_BYPASS).
- Control decode and immediate extension stay inline in decode_cycle.

Test Plan:
1. Hold rst=0 with InstrD=0xFFD00293 and clock running -> every output 0. Release, InstrD=0x00000000 -> all control 0 after the edge.
2. InstrD=0xFFD00293 (addi x5,x0,-3) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=0xFFFFFFFD, RD_E=5, RS1_E=0, RD1_E=0.
3. RegWriteW=1, RDW=6, ResultW=0x12345678 in the same cycle as InstrD=0x006303B3 (add x7,x6,x6) -> RD1_E=RD2_E=0x12345678, ALUControlE=000, RD_E=7. The following cycle, the same instruction with RegWriteW=0 -> still 0x12345678.
4. RegWriteW=1, RDW=0, ResultW=0xDEADBEEF, then InstrD=0x00000033 (add x0,x0,x0) -> RD1_E=RD2_E=0.
5. InstrD=0xFE208CE3 (beq x1,x2,-8), PCD=0x40 -> BranchE=1, ALUControlE=001, RegWriteE=0, Imm_Ext_E=0xFFFFFFF8, RS1_E=1, RS2_E=2, PCE=0x40.
6. Valid addi in flight plus FlushE=1 -> next edge all outputs 0. Then drop rst mid-cycle while a decoded lw is held -> outputs 0 immediately; registers read 0 after release.
